// File: rtl/rx_buf_rd_arb.sv
// Round-robin arbiter that lets NUM_REQ requesters share one rx-buffer read channel.
// One transaction is outstanding at a time: the winner's request is latched and issued,
// then the reader's response beats are steered to that requester until the last beat.
module rx_buf_rd_arb #(
   parameter int unsigned NUM_REQ    = 2,
   parameter int unsigned FLOWID_W   = 8,
   parameter int unsigned BUF_PTR_W  = 16,
   parameter int unsigned MSG_SIZE_W = 16,
   parameter int unsigned NOC_DATA_W = 512,
   parameter int unsigned NOC_PAD_W  = 6,
   parameter int unsigned GRANT_W    = $clog2(NUM_REQ)
) (
   input  logic                            clk_i,
   input  logic                            rst_ni,

   input  logic [NUM_REQ-1:0]              src_req_val_i,
   input  logic [NUM_REQ*FLOWID_W-1:0]     src_req_flowid_i,
   input  logic [NUM_REQ*BUF_PTR_W-1:0]    src_req_offset_i,
   input  logic [NUM_REQ*MSG_SIZE_W-1:0]   src_req_size_i,
   output logic [NUM_REQ-1:0]              src_req_rdy_o,

   output logic [NUM_REQ-1:0]              src_resp_val_o,
   output logic [NOC_DATA_W-1:0]           src_resp_data_o,
   output logic                            src_resp_last_o,
   output logic [NOC_PAD_W-1:0]            src_resp_padbytes_o,
   input  logic [NUM_REQ-1:0]              src_resp_rdy_i,

   output logic                            rd_buf_req_val_o,
   output logic [FLOWID_W-1:0]             rd_buf_req_flowid_o,
   output logic [BUF_PTR_W-1:0]            rd_buf_req_offset_o,
   output logic [MSG_SIZE_W-1:0]           rd_buf_req_size_o,
   input  logic                            rd_buf_req_rdy_i,

   input  logic                            rd_buf_resp_val_i,
   input  logic [NOC_DATA_W-1:0]           rd_buf_resp_data_i,
   input  logic                            rd_buf_resp_last_i,
   input  logic [NOC_PAD_W-1:0]            rd_buf_resp_padbytes_i,
   output logic                            rd_buf_resp_rdy_o,

   output logic                            arb_busy_o,
   output logic [GRANT_W-1:0]              arb_grant_o
);

   typedef enum logic [1:0] {StIdle, StIssue, StDrain} state_e;

   state_e                 state_q;
   logic [GRANT_W-1:0]     rr_ptr_q;
   logic [GRANT_W-1:0]     grant_q;
   logic [FLOWID_W-1:0]    flowid_q;
   logic [BUF_PTR_W-1:0]   offset_q;
   logic [MSG_SIZE_W-1:0]  size_q;
   logic                   busy_q;
   logic                   req_val_q;

   logic                   win_found;
   logic [GRANT_W-1:0]     win_idx;
   logic [GRANT_W-1:0]     cand;
   logic [FLOWID_W-1:0]    win_flowid;
   logic [BUF_PTR_W-1:0]   win_offset;
   logic [MSG_SIZE_W-1:0]  win_size;
   logic                   resp_hs;

   // Index increment with wrap at NUM_REQ (NUM_REQ need not be a power of two).
   function automatic logic [GRANT_W-1:0] wrap_inc(input logic [GRANT_W-1:0] idx);
      if (32'(idx) == NUM_REQ - 1) begin
         return '0;
      end
      return idx + 1'b1;
   endfunction

   // Pick the first valid requester at or above rr_ptr, wrapping around.
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      cand      = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         cand = GRANT_W'((32'(rr_ptr_q) + i) % NUM_REQ);
         if (!win_found && src_req_val_i[cand]) begin
            win_found = 1'b1;
            win_idx   = cand;
         end
      end
   end

   assign win_flowid = src_req_flowid_i[32'(win_idx)*FLOWID_W +: FLOWID_W];
   assign win_offset = src_req_offset_i[32'(win_idx)*BUF_PTR_W +: BUF_PTR_W];
   assign win_size   = src_req_size_i[32'(win_idx)*MSG_SIZE_W +: MSG_SIZE_W];

   assign resp_hs = (state_q == StDrain) && rd_buf_resp_val_i && src_resp_rdy_i[grant_q];

   // Request accept to the winner only, and only while idle.
   always_comb begin
      src_req_rdy_o = '0;
      if (state_q == StIdle && win_found) begin
         src_req_rdy_o[win_idx] = 1'b1;
      end
   end

   // Steer reader beats to the granted requester; back-pressure the reader otherwise.
   always_comb begin
      src_resp_val_o    = '0;
      rd_buf_resp_rdy_o = 1'b0;
      if (state_q == StDrain) begin
         src_resp_val_o[grant_q] = rd_buf_resp_val_i;
         rd_buf_resp_rdy_o       = src_resp_rdy_i[grant_q];
      end
   end

   assign src_resp_data_o     = rd_buf_resp_data_i;
   assign src_resp_last_o     = rd_buf_resp_last_i;
   assign src_resp_padbytes_o = rd_buf_resp_padbytes_i;

   assign rd_buf_req_val_o    = req_val_q;
   assign rd_buf_req_flowid_o = flowid_q;
   assign rd_buf_req_offset_o = offset_q;
   assign rd_buf_req_size_o   = size_q;
   assign arb_busy_o          = busy_q;
   assign arb_grant_o         = grant_q;

   // Arbitration FSM with registered busy / request-valid outputs.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q   <= StIdle;
         rr_ptr_q  <= '0;
         grant_q   <= '0;
         flowid_q  <= '0;
         offset_q  <= '0;
         size_q    <= '0;
         busy_q    <= 1'b0;
         req_val_q <= 1'b0;
      end else begin
         case (state_q)
            StIdle: begin
               if (win_found) begin
                  grant_q <= win_idx;
                  if (win_size == '0) begin
                     // Empty read: retire at accept, nothing to issue.
                     rr_ptr_q <= wrap_inc(win_idx);
                  end else begin
                     flowid_q  <= win_flowid;
                     offset_q  <= win_offset;
                     size_q    <= win_size;
                     busy_q    <= 1'b1;
                     req_val_q <= 1'b1;
                     state_q   <= StIssue;
                  end
               end
            end
            StIssue: begin
               if (rd_buf_req_rdy_i) begin
                  req_val_q <= 1'b0;
                  state_q   <= StDrain;
               end
            end
            StDrain: begin
               if (resp_hs && rd_buf_resp_last_i) begin
                  busy_q   <= 1'b0;
                  rr_ptr_q <= wrap_inc(grant_q);
                  state_q  <= StIdle;
               end
            end
            default: begin
               busy_q    <= 1'b0;
               req_val_q <= 1'b0;
               state_q   <= StIdle;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_rx_buf_rd_arb.sv
// Directed bench for rx_buf_rd_arb with request and response-beat scoreboards.
module tb_rx_buf_rd_arb;

   localparam int unsigned NR = 2;
   localparam int unsigned FW = 8;
   localparam int unsigned PW = 16;
   localparam int unsigned SW = 16;
   localparam int unsigned DW = 64;
   localparam int unsigned AW = 3;
   localparam int unsigned GW = 1;

   typedef struct {
      int            r;
      logic [FW-1:0] fl;
      logic [PW-1:0] of;
      logic [SW-1:0] sz;
   } req_t;

   typedef struct {
      logic [DW-1:0] d;
      logic          l;
      logic [AW-1:0] p;
   } beat_t;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic [NR-1:0]     req_val = '0;
   logic [FW-1:0]     fl [NR];
   logic [PW-1:0]     of [NR];
   logic [SW-1:0]     sz [NR];
   logic [NR-1:0]     src_req_rdy;
   logic [NR-1:0]     src_resp_val;
   logic [DW-1:0]     src_resp_data;
   logic              src_resp_last;
   logic [AW-1:0]     src_resp_pad;
   logic [NR-1:0]     resp_rdy = '1;
   logic              rd_req_val;
   logic [FW-1:0]     rd_req_fl;
   logic [PW-1:0]     rd_req_of;
   logic [SW-1:0]     rd_req_sz;
   logic              rd_req_rdy = 1'b0;
   logic              rd_resp_val = 1'b0;
   logic [DW-1:0]     rd_resp_data = '0;
   logic              rd_resp_last = 1'b0;
   logic [AW-1:0]     rd_resp_pad = '0;
   logic              rd_resp_rdy;
   logic              arb_busy;
   logic [GW-1:0]     arb_grant;

   int n_checks = 0;
   int n_errors = 0;
   int hs_cnt = 0;
   req_t  req_q[$];
   beat_t beat_q[$];

   always #5 clk = ~clk;

   rx_buf_rd_arb #(
      .NUM_REQ    (NR),
      .FLOWID_W   (FW),
      .BUF_PTR_W  (PW),
      .MSG_SIZE_W (SW),
      .NOC_DATA_W (DW),
      .NOC_PAD_W  (AW),
      .GRANT_W    (GW)
   ) dut (
      .clk_i                  (clk),
      .rst_ni                 (rst_n),
      .src_req_val_i          (req_val),
      .src_req_flowid_i       ({fl[1], fl[0]}),
      .src_req_offset_i       ({of[1], of[0]}),
      .src_req_size_i         ({sz[1], sz[0]}),
      .src_req_rdy_o          (src_req_rdy),
      .src_resp_val_o         (src_resp_val),
      .src_resp_data_o        (src_resp_data),
      .src_resp_last_o        (src_resp_last),
      .src_resp_padbytes_o    (src_resp_pad),
      .src_resp_rdy_i         (resp_rdy),
      .rd_buf_req_val_o       (rd_req_val),
      .rd_buf_req_flowid_o    (rd_req_fl),
      .rd_buf_req_offset_o    (rd_req_of),
      .rd_buf_req_size_o      (rd_req_sz),
      .rd_buf_req_rdy_i       (rd_req_rdy),
      .rd_buf_resp_val_i      (rd_resp_val),
      .rd_buf_resp_data_i     (rd_resp_data),
      .rd_buf_resp_last_i     (rd_resp_last),
      .rd_buf_resp_padbytes_i (rd_resp_pad),
      .rd_buf_resp_rdy_o      (rd_resp_rdy),
      .arb_busy_o             (arb_busy),
      .arb_grant_o            (arb_grant)
   );

   // Count reader-side beat handshakes.
   always @(posedge clk) begin
      if (rd_resp_val && rd_resp_rdy) hs_cnt <= hs_cnt + 1;
   end

   initial begin
      #200000;
      $display("FAIL watchdog observed timeout expected completion");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Wait (bounded) for an accept and expect it on requester r; push the expected issue.
   task automatic accept(input int r);
      int n = 0;
      req_t e;
      @(negedge clk);
      while (src_req_rdy == '0 && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("accept_rdy", 64'(src_req_rdy), 64'(1 << r));
      check("accept_idle_busy", 64'(arb_busy), 64'(0));
      check("accept_no_issue", 64'(rd_req_val), 64'(0));
      e.r = r; e.fl = fl[r]; e.of = of[r]; e.sz = sz[r];
      req_q.push_back(e);
      @(posedge clk); #1;
   endtask

   // Check the issued request one cycle after accept, optionally stalling the reader.
   task automatic issue(input int stall);
      req_t e;
      @(negedge clk);
      check("issue_q_nonempty", 64'(req_q.size() != 0), 64'(1));
      e = req_q.pop_front();
      check("issue_val", 64'(rd_req_val), 64'(1));
      check("issue_flowid", 64'(rd_req_fl), 64'(e.fl));
      check("issue_offset", 64'(rd_req_of), 64'(e.of));
      check("issue_size", 64'(rd_req_sz), 64'(e.sz));
      check("issue_grant", 64'(arb_grant), 64'(e.r));
      check("issue_busy", 64'(arb_busy), 64'(1));
      for (int k = 0; k < stall; k++) begin
         @(posedge clk);
         @(negedge clk);
         check("stall_val", 64'(rd_req_val), 64'(1));
         check("stall_fields", {32'(rd_req_fl), rd_req_of, rd_req_sz},
               {32'(e.fl), e.of, e.sz});
         check("stall_src_rdy", 64'(src_req_rdy), 64'(0));
      end
      rd_req_rdy = 1'b1;
      @(posedge clk); #1;
      rd_req_rdy = 1'b0;
   endtask

   // Act as the reader for nb beats to requester r, optionally stalling requester r.
   task automatic drain(input int r, input int nb, input int stall_at, input int stall_len);
      beat_t b;
      int hs0 = hs_cnt;
      for (int i = 0; i < nb; i++) begin
         b.d = {$urandom, $urandom};
         b.l = (i == nb - 1);
         b.p = AW'($urandom_range(0, 7));
         beat_q.push_back(b);
         rd_resp_val = 1'b1; rd_resp_data = b.d; rd_resp_last = b.l; rd_resp_pad = b.p;
         if (i == stall_at) begin
            resp_rdy[r] = 1'b0;
            for (int k = 0; k < stall_len; k++) begin
               @(negedge clk);
               check("bp_rdy", 64'(rd_resp_rdy), 64'(0));
               check("bp_val", 64'(src_resp_val), 64'(1 << r));
               check("bp_data", src_resp_data, b.d);
               check("bp_count", 64'(hs_cnt - hs0), 64'(i));
               @(posedge clk); #1;
            end
            resp_rdy[r] = 1'b1;
         end
         @(negedge clk);
         check("beat_q_nonempty", 64'(beat_q.size() != 0), 64'(1));
         b = beat_q.pop_front();
         check("beat_val", 64'(src_resp_val), 64'(1 << r));
         check("beat_rdy", 64'(rd_resp_rdy), 64'(1));
         check("beat_data", src_resp_data, b.d);
         check("beat_last", 64'(src_resp_last), 64'(b.l));
         check("beat_pad", 64'(src_resp_pad), 64'(b.p));
         @(posedge clk); #1;
      end
      rd_resp_val = 1'b0; rd_resp_last = 1'b0;
      check("beat_count", 64'(hs_cnt - hs0), 64'(nb));
   endtask

   initial begin
      fl[0] = 8'd3; of[0] = 16'h0040; sz[0] = 16'd128;
      fl[1] = 8'd5; of[1] = 16'h0080; sz[1] = 16'd64;

      // Reset state
      #12;
      check("rst_busy", 64'(arb_busy), 64'(0));
      check("rst_req_val", 64'(rd_req_val), 64'(0));
      check("rst_resp_rdy", 64'(rd_resp_rdy), 64'(0));
      check("rst_src_resp_val", 64'(src_resp_val), 64'(0));
      check("rst_grant", 64'(arb_grant), 64'(0));
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;

      // Single requester 0, two beats
      req_val = 2'b01;
      accept(0);
      req_val = 2'b00;
      issue(0);
      drain(0, 2, -1, 0);
      @(negedge clk);
      check("idle_busy", 64'(arb_busy), 64'(0));
      @(posedge clk); #1;

      // Zero-size request from requester 1
      req_val = 2'b10; sz[1] = '0;
      @(negedge clk);
      check("zero_rdy", 64'(src_req_rdy), 64'(2'b10));
      @(posedge clk); #1;
      req_val = 2'b00; sz[1] = 16'd64;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check("zero_no_issue", 64'(rd_req_val), 64'(0));
         check("zero_busy", 64'(arb_busy), 64'(0));
         @(posedge clk); #1;
      end

      // Both held: grants 0,1,0,1 with issue and response back-pressure
      req_val = 2'b11;
      accept(0);
      issue(0);
      drain(0, 2, -1, 0);
      accept(1);
      issue(10);
      drain(1, 3, 1, 5);
      accept(0);
      issue(0);
      drain(0, 1, -1, 0);
      accept(1);
      issue(0);

      // Reset in the middle of requester 1's burst
      req_val = 2'b00;
      rd_resp_val = 1'b1; rd_resp_data = 64'hdead_beef_0123_4567; rd_resp_last = 1'b0;
      @(negedge clk);
      check("pre_rst_val", 64'(src_resp_val), 64'(2'b10));
      #2 rst_n = 1'b0;
      #1;
      check("mid_rst_busy", 64'(arb_busy), 64'(0));
      check("mid_rst_req_val", 64'(rd_req_val), 64'(0));
      check("mid_rst_resp_rdy", 64'(rd_resp_rdy), 64'(0));
      check("mid_rst_src_resp_val", 64'(src_resp_val), 64'(0));
      check("mid_rst_grant", 64'(arb_grant), 64'(0));
      rd_resp_val = 1'b0;
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;

      req_val = 2'b10;
      accept(1);
      req_val = 2'b00;
      issue(0);
      drain(1, 2, -1, 0);

      check("req_q_empty", 64'(req_q.size()), 64'(0));
      check("beat_q_empty", 64'(beat_q.size()), 64'(0));

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/rx_buf_rd_arb.md
RX_BUF_RD_ARB -- requirements
Module: rx_buf_rd_arb

Interface
REQ-001 Parameter NUM_REQ, default 2, number of requesters sharing one rx-buffer read channel (2..8).
REQ-002 Parameter FLOWID_W, default FLOWID_W from the package, flow ID width.
REQ-003 Parameter BUF_PTR_W, default RX_PAYLOAD_PTR_W, buffer offset width.
REQ-004 Parameter GRANT_W, default $clog2(NUM_REQ), grant index width.
REQ-005 clk  in  1  sole clock; all state on rising edge.
REQ-006 rst  in  1  asynchronous, active-low reset.
REQ-007 src_req_val  in  NUM_REQ  per-requester read request valid.
REQ-008 src_req_flowid  in  NUM_REQ*FLOWID_W  packed flow IDs, requester i at slice i.
REQ-009 src_req_offset  in  NUM_REQ*BUF_PTR_W  packed start offsets.
REQ-010 src_req_size  in  NUM_REQ*`MSG_DATA_SIZE_WIDTH  packed byte counts.
REQ-011 src_req_rdy  out  NUM_REQ  per-requester request accept.
REQ-012 src_resp_val  out  NUM_REQ  per-requester response beat valid.
REQ-013 src_resp_data / _last / _padbytes  out  `NOC_DATA_WIDTH / 1 / `NOC_PADBYTES_WIDTH  response beat, broadcast to all requesters.
REQ-014 src_resp_rdy  in  NUM_REQ  per-requester response accept.
REQ-015 rd_buf_req_val / _flowid / _offset / _size  out  1 / FLOWID_W / BUF_PTR_W / `MSG_DATA_SIZE_WIDTH  request to the circular-buffer reader.
REQ-016 rd_buf_req_rdy  in  1  reader request accept.
REQ-017 rd_buf_resp_val / _data / _last / _padbytes  in  1 / `NOC_DATA_WIDTH / 1 / `NOC_PADBYTES_WIDTH  reader response beat.
REQ-018 rd_buf_resp_rdy  out  1  response accept to reader.
REQ-019 arb_busy  out  1  high in any state except IDLE; arb_grant  out  GRANT_W  current/last grant index.

Function
REQ-020 FSM states SHALL be IDLE, ISSUE, DRAIN; exactly one transaction outstanding at any time.
REQ-021 IDLE: winner = first asserted src_req_val scanning upward from rr_ptr with wrap; src_req_rdy[winner]=1 combinationally, all other src_req_rdy=0.
REQ-022 IDLE handshake: winner's flowid/offset/size latched into registers, arb_grant=winner, next state ISSUE.
REQ-023 Zero-size request: accepted in IDLE, nothing issued, rr_ptr=(winner+1) mod NUM_REQ, state stays IDLE.
REQ-024 ISSUE: rd_buf_req_val=1 with latched fields held stable; on rd_buf_req_rdy -> DRAIN; all src_req_rdy=0.
REQ-025 DRAIN: src_resp_val[arb_grant]=rd_buf_resp_val, other src_resp_val=0; rd_buf_resp_rdy=src_resp_rdy[arb_grant]; data/last/padbytes passed through combinationally.
REQ-026 DRAIN: beat with rd_buf_resp_last and handshake -> IDLE, rr_ptr=(arb_grant+1) mod NUM_REQ.
REQ-027 Outside DRAIN: rd_buf_resp_rdy=0 and all src_resp_val=0; stray reader beats are back-pressured, never dropped.
REQ-028 Latency: accept at cycle N -> rd_buf_req_val at N+1; last-beat handshake at M -> next accept possible at M+1.
REQ-029 Requester deasserting src_req_val without handshake: no effect; arbitration re-evaluated each IDLE cycle.
REQ-030 Fairness: every continuously asserting requester granted within NUM_REQ transactions.

Reset
REQ-031 On rst low, asynchronously: state=IDLE, rr_ptr=0, arb_grant=0, latched fields=0; arb_busy, rd_buf_req_val, rd_buf_resp_rdy, all src_resp_val=0.
REQ-032 Reset mid-transaction SHALL abandon it; first cycle after release is IDLE with requester 0 highest priority.

Verification
REQ-033 NUM_REQ=2, req0 (flow 3, off 0x40, size 128) alone -> src_req_rdy[0] cycle 0, rd_buf_req_val cycle 1 with same fields, 2 beats to src_resp_val[0] only, arb_busy low after last.
REQ-034 Both requesters held valid from reset -> grant order 0,1,0,1; arb_grant matches; no interleaving of response beats.
REQ-035 req1 asserts size 0 with req0 idle -> src_req_rdy[1] one cycle, rd_buf_req_val never asserts, next grant prefers req0.
REQ-036 src_resp_rdy[granted]=0 for 5 cycles mid-burst -> rd_buf_resp_rdy=0 those cycles, data held, beat count unchanged.
REQ-037 rd_buf_req_rdy held low 10 cycles in ISSUE -> rd_buf_req_val and fields stable, src_req_rdy all 0.
REQ-038 rst asserted during DRAIN -> outputs zero immediately; after release a new req1 request issues normally.
